// File: rtl/mont_exp_ctrl_if.sv
// Bus between the modular exponentiation controller, its caller and the
// Montgomery multiplier. The controller uses the slave view; the caller and
// multiplier together use the master view.
interface mont_exp_ctrl_if #(
   parameter int W  = 512,
   parameter int EW = 512
) ();
   // caller request side
   logic          start;
   logic [W-1:0]  in_x;
   logic [EW-1:0] in_e;
   logic [W-1:0]  in_m;
   logic [W-1:0]  in_rmodm;
   logic [W-1:0]  in_r2modm;
   logic [W-1:0]  result;
   logic          done;
   logic          busy;
   // multiplier side
   logic          mm_resetn;
   logic          mm_start;
   logic [W-1:0]  mm_a;
   logic [W-1:0]  mm_b;
   logic [W-1:0]  mm_m;
   logic [W-1:0]  mm_result;
   logic          mm_done;

   modport slave (
      input  start, in_x, in_e, in_m, in_rmodm, in_r2modm, mm_result, mm_done,
      output result, done, busy, mm_resetn, mm_start, mm_a, mm_b, mm_m
   );

   modport master (
      output start, in_x, in_e, in_m, in_rmodm, in_r2modm, mm_result, mm_done,
      input  result, done, busy, mm_resetn, mm_start, mm_a, mm_b, mm_m
   );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Modular exponentiation controller: result = x^e mod m by left-to-right
// square-and-multiply, driving a single Montgomery multiplier serially.
// Every multiplication runs the same ISSUE -> WAIT -> CAPT handshake; the
// multiplier is reset in each CAPT so its level done never carries over.
module mont_exp_ctrl #(
   parameter int W  = 512,
   parameter int EW = 512
) (
   input  logic              clk,
   input  logic              resetn,
   mont_exp_ctrl_if.slave    bus
);
   localparam int CW = $clog2(EW) + 1;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_TOMONT   = 3'd1;
   localparam logic [2:0] S_SQR      = 3'd2;
   localparam logic [2:0] S_MUL      = 3'd3;
   localparam logic [2:0] S_FROMMONT = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;

   localparam logic [1:0] P_ISSUE = 2'd0;
   localparam logic [1:0] P_WAIT  = 2'd1;
   localparam logic [1:0] P_CAPT  = 2'd2;

   logic [2:0]    state;
   logic [1:0]    phase;
   logic [W-1:0]  xm;
   logic [W-1:0]  acc;
   logic [EW-1:0] ebuf;
   logic [CW-1:0] bitcnt;

   logic          in_op;
   logic          clr;
   logic [CW-1:0] bitcnt_dec;
   logic [EW-1:0] ebuf_shl;

   // Multiplier is cleared in the capture cycle of every operation so the
   // next ISSUE never sees a stale done.
   always_comb begin
      in_op      = (state == S_TOMONT) || (state == S_SQR) ||
                   (state == S_MUL)    || (state == S_FROMMONT);
      clr        = in_op && (phase == P_CAPT);
      bitcnt_dec = bitcnt - CW'(1);
      ebuf_shl   = {ebuf[EW-2:0], 1'b0};
   end

   assign bus.mm_resetn = resetn & ~clr;

   // Operation sequencer: selects the next multiplication, loads its
   // operands during capture and emits the one-cycle start pulse.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= S_IDLE;
         phase        <= P_ISSUE;
         xm           <= '0;
         acc          <= '0;
         ebuf         <= '0;
         bitcnt       <= '0;
         bus.result   <= '0;
         bus.done     <= 1'b0;
         bus.busy     <= 1'b0;
         bus.mm_start <= 1'b0;
         bus.mm_a     <= '0;
         bus.mm_b     <= '0;
         bus.mm_m     <= '0;
      end else begin
         bus.mm_start <= 1'b0;
         bus.done     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  // First op converts x into Montgomery form; acc starts at R mod m.
                  bus.mm_a     <= bus.in_x;
                  bus.mm_b     <= bus.in_r2modm;
                  bus.mm_m     <= bus.in_m;
                  acc          <= bus.in_rmodm;
                  ebuf         <= bus.in_e;
                  bitcnt       <= CW'(EW);
                  bus.busy     <= 1'b1;
                  bus.mm_start <= 1'b1;
                  phase        <= P_ISSUE;
                  state        <= S_TOMONT;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               case (phase)
                  P_ISSUE: begin
                     phase <= P_WAIT;
                  end
                  P_WAIT: begin
                     if (bus.mm_done) begin
                        phase <= P_CAPT;
                     end
                  end
                  default: begin
                     phase <= P_ISSUE;
                     case (state)
                        S_TOMONT: begin
                           xm           <= bus.mm_result;
                           bus.mm_a     <= acc;
                           bus.mm_b     <= acc;
                           bus.mm_start <= 1'b1;
                           state        <= S_SQR;
                        end
                        S_SQR, S_MUL: begin
                           acc          <= bus.mm_result;
                           bus.mm_start <= 1'b1;
                           if ((state == S_SQR) && ebuf[EW-1]) begin
                              bus.mm_a <= bus.mm_result;
                              bus.mm_b <= xm;
                              state    <= S_MUL;
                           end else begin
                              // Current exponent bit fully processed.
                              ebuf   <= ebuf_shl;
                              bitcnt <= bitcnt_dec;
                              if (bitcnt_dec == '0) begin
                                 bus.mm_a <= bus.mm_result;
                                 bus.mm_b <= W'(1);
                                 state    <= S_FROMMONT;
                              end else begin
                                 bus.mm_a <= bus.mm_result;
                                 bus.mm_b <= bus.mm_result;
                                 state    <= S_SQR;
                              end
                           end
                        end
                        default: begin
                           // Back to the normal domain: publish the result.
                           acc        <= bus.mm_result;
                           bus.result <= bus.mm_result;
                           bus.done   <= 1'b1;
                           bus.busy   <= 1'b0;
                           state      <= S_DONE;
                        end
                     endcase
                  end
               endcase
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl at W=EW=8 with a behavioural Montgomery multiplier
// (latency 12). Expected results and op counts go into a scoreboard queue
// when start is driven and are popped when done is seen.
module tb_mont_exp_ctrl;
   localparam int W   = 8;
   localparam int EW  = 8;
   localparam int M   = 241;
   localparam int RM  = 15;
   localparam int R2  = 225;
   localparam int LAT = 12;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   mont_exp_ctrl_if #(.W(W), .EW(EW)) bus ();

   mont_exp_ctrl #(.W(W), .EW(EW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int vectors = 0;
   int fails   = 0;
   int mm_pulses = 0;
   int done_cnt  = 0;
   int stab_err  = 0;
   int stale_err = 0;
   int pulse_base = 0;
   int exp_res_q[$];
   int exp_ops_q[$];

   function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
      logic [2*W+1:0] t;
      t = (2*W+2)'(a) * (2*W+2)'(b);
      for (int i = 0; i < W; i++) begin
         if (t[0]) t = t + (2*W+2)'(m);
         t = t >> 1;
      end
      if (t >= (2*W+2)'(m)) t = t - (2*W+2)'(m);
      return t[W-1:0];
   endfunction

   function automatic int ref_pow(input int x, input logic [EW-1:0] e, input int m);
      longint r, b;
      r = 1 % m;
      b = x % m;
      for (int i = 0; i < EW; i++) begin
         if (e[i]) r = (r * b) % m;
         b = (b * b) % m;
      end
      return int'(r);
   endfunction

   // behavioural multiplier
   logic [W-1:0] ma, mb, mmod;
   int  mcnt;
   logic mbusy;
   always @(posedge clk) begin
      if (!bus.mm_resetn) begin
         mbusy         <= 1'b0;
         mcnt          <= 0;
         bus.mm_done   <= 1'b0;
         bus.mm_result <= '0;
      end else if (bus.mm_start) begin
         if (bus.mm_done) stale_err <= stale_err + 1;
         ma    <= bus.mm_a;
         mb    <= bus.mm_b;
         mmod  <= bus.mm_m;
         mbusy <= 1'b1;
         mcnt  <= LAT - 1;
      end else if (mbusy) begin
         if ((bus.mm_a !== ma) || (bus.mm_b !== mb)) stab_err <= stab_err + 1;
         if (mcnt == 0) begin
            mbusy         <= 1'b0;
            bus.mm_done   <= 1'b1;
            bus.mm_result <= mont_mul(ma, mb, mmod);
         end else begin
            mcnt <= mcnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (bus.mm_start === 1'b1) mm_pulses <= mm_pulses + 1;
      if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic drive_start(input logic [W-1:0] x, input logic [EW-1:0] e);
      @(negedge clk);
      bus.in_x      = x;
      bus.in_e      = e;
      bus.in_m      = W'(M);
      bus.in_rmodm  = W'(RM);
      bus.in_r2modm = W'(R2);
      bus.start     = 1'b1;
      exp_res_q.push_back(ref_pow(int'(x), e, M));
      exp_ops_q.push_back(EW + $countones(e) + 2);
      pulse_base = mm_pulses;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output bit ok, output int busy_drops);
      ok = 1'b0;
      busy_drops = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         if (bus.busy !== 1'b1) busy_drops++;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (bus.result !== 8'd0) begin fails++; $display("FAIL reset_result got %0d want 0", bus.result); end
      vectors++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
      vectors++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      vectors++; if (bus.mm_start !== 1'b0) begin fails++; $display("FAIL reset_mm_start got %b want 0", bus.mm_start); end
      vectors++; if (bus.mm_resetn !== 1'b0) begin fails++; $display("FAIL reset_mm_resetn got %b want 0", bus.mm_resetn); end
      vectors++; if ({bus.mm_a, bus.mm_b, bus.mm_m} !== 24'd0) begin fails++; $display("FAIL reset_mm_ops got %h want 0", {bus.mm_a, bus.mm_b, bus.mm_m}); end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bit ok; int drops; int er, eo; int d0;
      d0 = done_cnt;
      drive_start(8'd3, 8'd5);
      wait_done(ok, drops);
      er = exp_res_q.pop_front(); eo = exp_ops_q.pop_front();
      vectors++; if (!ok) begin fails++; $display("FAIL basic_timeout got no done want done"); end
      vectors++; if (int'(bus.result) !== er || er !== 2) begin fails++; $display("FAIL basic_result got %0d want %0d", bus.result, er); end
      vectors++; if (mm_pulses - pulse_base !== eo) begin fails++; $display("FAIL basic_ops got %0d want %0d", mm_pulses - pulse_base, eo); end
      vectors++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done got %b want 0", bus.busy); end
      repeat (20) @(negedge clk);
      vectors++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); end
      vectors++; if (int'(bus.result) !== er) begin fails++; $display("FAIL basic_result_held got %0d want %0d", bus.result, er); end
   endtask

   task automatic test_small_exps();
      bit ok; int drops; int er, eo;
      logic [W-1:0] xs [2] = '{8'd200, 8'd77};
      logic [EW-1:0] es [2] = '{8'd1, 8'd0};
      for (int k = 0; k < 2; k++) begin
         drive_start(xs[k], es[k]);
         wait_done(ok, drops);
         er = exp_res_q.pop_front(); eo = exp_ops_q.pop_front();
         vectors++; if (!ok) begin fails++; $display("FAIL small_timeout[%0d] got no done want done", k); end
         vectors++; if (int'(bus.result) !== er) begin fails++; $display("FAIL small_result[%0d] got %0d want %0d", k, bus.result, er); end
         vectors++; if (mm_pulses - pulse_base !== eo) begin fails++; $display("FAIL small_ops[%0d] got %0d want %0d", k, mm_pulses - pulse_base, eo); end
      end
   endtask

   task automatic test_all_ones();
      bit ok; int drops; int er, eo;
      drive_start(8'd2, 8'hFF);
      wait_done(ok, drops);
      er = exp_res_q.pop_front(); eo = exp_ops_q.pop_front();
      vectors++; if (!ok) begin fails++; $display("FAIL ones_timeout got no done want done"); end
      vectors++; if (int'(bus.result) !== er) begin fails++; $display("FAIL ones_result got %0d want %0d", bus.result, er); end
      vectors++; if (mm_pulses - pulse_base !== 18) begin fails++; $display("FAIL ones_ops got %0d want 18", mm_pulses - pulse_base); end
      vectors++; if (drops !== 0) begin fails++; $display("FAIL ones_busy_drops got %0d want 0", drops); end
   endtask

   task automatic test_ignore_busy();
      bit ok; int drops; int er, eo;
      drive_start(8'd3, 8'd5);
      repeat (20) @(negedge clk);
      bus.in_x  = 8'd5;
      bus.in_e  = 8'hFF;
      bus.in_m  = 8'd239;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(ok, drops);
      er = exp_res_q.pop_front(); eo = exp_ops_q.pop_front();
      vectors++; if (!ok) begin fails++; $display("FAIL ignore_timeout got no done want done"); end
      vectors++; if (int'(bus.result) !== er) begin fails++; $display("FAIL ignore_result got %0d want %0d", bus.result, er); end
      vectors++; if (mm_pulses - pulse_base !== eo) begin fails++; $display("FAIL ignore_ops got %0d want %0d", mm_pulses - pulse_base, eo); end
      vectors++; if (int'(bus.mm_m) !== M) begin fails++; $display("FAIL ignore_mm_m got %0d want %0d", bus.mm_m, M); end
   endtask

   task automatic test_reset_mid();
      bit ok; int drops; int er, eo;
      drive_start(8'd3, 8'd5);
      repeat (30) @(negedge clk);
      resetn = 1'b0;
      void'(exp_res_q.pop_back());
      void'(exp_ops_q.pop_back());
      @(negedge clk);
      vectors++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
      vectors++; if (bus.result !== 8'd0) begin fails++; $display("FAIL midrst_result got %0d want 0", bus.result); end
      vectors++; if (bus.mm_resetn !== 1'b0) begin fails++; $display("FAIL midrst_mm_resetn got %b want 0", bus.mm_resetn); end
      vectors++; if (bus.mm_start !== 1'b0) begin fails++; $display("FAIL midrst_mm_start got %b want 0", bus.mm_start); end
      resetn = 1'b1;
      @(negedge clk);
      drive_start(8'd10, 8'd77);
      wait_done(ok, drops);
      er = exp_res_q.pop_front(); eo = exp_ops_q.pop_front();
      vectors++; if (!ok) begin fails++; $display("FAIL midrst_timeout got no done want done"); end
      vectors++; if (int'(bus.result) !== er) begin fails++; $display("FAIL midrst_result_after got %0d want %0d", bus.result, er); end
      vectors++; if (mm_pulses - pulse_base !== eo) begin fails++; $display("FAIL midrst_ops got %0d want %0d", mm_pulses - pulse_base, eo); end
   endtask

   task automatic test_back_to_back();
      bit ok; int drops; int er, eo;
      logic [W-1:0] x;
      logic [EW-1:0] e;
      for (int k = 0; k < 4; k++) begin
         x = W'($urandom_range(M - 1, 0));
         e = EW'($urandom_range(255, 0));
         drive_start(x, e);
         wait_done(ok, drops);
         er = exp_res_q.pop_front(); eo = exp_ops_q.pop_front();
         vectors++; if (!ok) begin fails++; $display("FAIL b2b_timeout[%0d] got no done want done", k); end
         vectors++; if (int'(bus.result) !== er) begin fails++; $display("FAIL b2b_result[%0d] x=%0d e=%0d got %0d want %0d", k, x, e, bus.result, er); end
         vectors++; if (mm_pulses - pulse_base !== eo) begin fails++; $display("FAIL b2b_ops[%0d] got %0d want %0d", k, mm_pulses - pulse_base, eo); end
      end
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.in_x      = '0;
      bus.in_e      = '0;
      bus.in_m      = W'(M);
      bus.in_rmodm  = W'(RM);
      bus.in_r2modm = W'(R2);
      test_reset();
      test_basic();
      test_small_exps();
      test_all_ones();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
      vectors++; if (stab_err !== 0) begin fails++; $display("FAIL operand_stability got %0d changes want 0", stab_err); end
      vectors++; if (stale_err !== 0) begin fails++; $display("FAIL stale_done_at_issue got %0d want 0", stale_err); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
